// File: rtl/iter_shift_unit_pkg.sv
// Shared encodings for the iterative shift unit and its single-step shifter:
// shift operation codes and controller state codes.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_PASS = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } st_e;

endpackage

// File: rtl/iter_shift_unit_if.sv
// Start/done handshake and operand/result bus of the iterative shift unit.
// The master (controller) issues start/op/amount/din; the slave (shift unit)
// returns busy/done/dout.
interface iter_shift_unit_if #(
  parameter int N  = 16,
  parameter int AW = 4
);
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] amount;
  logic [N-1:0]  din;
  logic          busy;
  logic          done;
  logic [N-1:0]  dout;

  modport master (
    output start, op, amount, din,
    input  busy, done, dout
  );

  modport slave (
    input  start, op, amount, din,
    output busy, done, dout
  );
endinterface

// File: rtl/iter_shift_unit_shifter.sv
// Single-step shifter: moves b by one bit position according to the op code.
// Left fills the LSB with 0, logical right fills the MSB with 0, arithmetic
// right replicates the MSB; pass returns b unchanged.
module shifter
  import shift_pkg::*;
#(
  parameter int m = 2,
  parameter int n = 16
) (
  input  logic [m-1:0] shift,
  input  logic [n-1:0] b,
  output logic [n-1:0] y
);

  // One-position shift selected by the op code
  always_comb begin
    y = b;
    case (sh_op_e'(shift[1:0]))
      SH_LSL:  y = {b[n-2:0], 1'b0};
      SH_LSR:  y = {1'b0, b[n-1:1]};
      SH_ASR:  y = {b[n-1], b[n-1:1]};
      default: y = b;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift unit: shifts an N-bit operand by 0..2^AW-1 positions,
// one bit per clock through the single-step shifter, with a start/done
// handshake. busy covers SHIFT and DONE; done pulses for one cycle when dout
// holds the result, and dout keeps it until the next accepted start.
// Optional build macro ITER_SHIFT_FAST_EN: the full shift is applied in one
// cycle (barrel form) and the unit goes straight from IDLE to DONE.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  iter_shift_unit_if.slave  bus
);

  st_e           state_q;
  sh_op_e        op_q;
  logic [AW-1:0] count_q;
  logic [N-1:0]  dout_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  step_d;

`ifdef ITER_SHIFT_FAST_EN
  // Whole-amount shift of the operand, same fill rules as the 1-bit step
  function automatic logic [N-1:0] barrel(input sh_op_e op,
                                          input logic [N-1:0] d,
                                          input logic [AW-1:0] amt);
    logic [N-1:0] r;
    case (op)
      SH_LSL:  r = d << amt;
      SH_LSR:  r = d >> amt;
      SH_ASR:  r = N'($signed(d) >>> amt);
      default: r = d;
    endcase
    return r;
  endfunction
`endif

  shifter #(
    .m(2),
    .n(N)
  ) u_step (
    .shift(op_q),
    .b    (dout_q),
    .y    (step_d)
  );

  // Controller FSM with result register, step counter and registered status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= SH_PASS;
      count_q <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_q   <= sh_op_e'(bus.op);
            busy_q <= 1'b1;
`ifdef ITER_SHIFT_FAST_EN
            dout_q  <= barrel(sh_op_e'(bus.op), bus.din, bus.amount);
            count_q <= '0;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
`else
            dout_q  <= bus.din;
            count_q <= bus.amount;
            // Nothing to iterate for pass or a zero amount
            if ((bus.amount != '0) && (sh_op_e'(bus.op) != SH_PASS)) begin
              state_q <= ST_SHIFT;
              done_q  <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
`endif
          end
        end
        ST_SHIFT: begin
          dout_q  <= step_d;
          count_q <= count_q - 1'b1;
          // SHIFT is only entered with count >= 1, so this never underflows
          if (count_q == AW'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit with a scoreboard of expected
// results (value and latency) pushed at launch and popped at done.
module tb_iter_shift_unit;

  localparam int N  = 16;
  localparam int AW = 4;

  logic clk;
  logic reset;

  iter_shift_unit_if #(.N(N), .AW(AW)) bus ();

  iter_shift_unit #(.N(N), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  function automatic logic [N-1:0] model_res(logic [1:0] op, logic [AW-1:0] amt, logic [N-1:0] d);
    logic [N-1:0] r;
    case (op)
      2'b01:   r = d << amt;
      2'b10:   r = d >> amt;
      2'b11:   r = $signed(d) >>> amt;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int model_lat(logic [1:0] op, logic [AW-1:0] amt);
`ifdef ITER_SHIFT_FAST_EN
    return 1;
`else
    return (op == 2'b00 || amt == '0) ? 1 : int'(amt) + 1;
`endif
  endfunction

  // Present a one-cycle start, record the expectation, scramble inputs after
  task automatic launch(input logic [1:0] op, input logic [AW-1:0] amt, input logic [N-1:0] d);
    exp_t e;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.amount = amt;
    bus.din    = d;
    e.res = model_res(op, amt, d);
    e.lat = model_lat(op, amt);
    sb.push_back(e);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op     = ~op;
    bus.amount = ~amt;
    bus.din    = ~d ^ 16'h5A5A;
    cyc = 1;
  endtask

  task automatic wait_done(input bit chk_idle);
    exp_t e;
    while (bus.done !== 1'b1 && cyc < 64) begin
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_during_op: got %b required 1 (cycle %0d)", bus.busy, cyc);
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries required 1");
    end else begin
      e = sb.pop_front();
      if (bus.done !== 1'b1) begin
        n_fail++;
        $display("FAIL done_timeout: got no done after %0d cycles required done at %0d", cyc, e.lat);
      end else begin
        if (bus.dout !== e.res) begin
          n_fail++;
          $display("FAIL dout: got %h required %h", bus.dout, e.res);
        end
        n_checks++;
        if (cyc != e.lat) begin
          n_fail++;
          $display("FAIL latency: got %0d required %0d", cyc, e.lat);
        end
        n_checks++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_at_done: got %b required 1", bus.busy);
        end
      end
      if (chk_idle) begin
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_after_done: got busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        n_checks++;
        if (bus.dout !== e.res) begin
          n_fail++;
          $display("FAIL dout_hold: got %h required %h", bus.dout, e.res);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.amount = '0;
    bus.din    = '0;
    #3;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dout !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b dout=%h required 0 0 0000", bus.busy, bus.done, bus.dout);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_idle: got busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_lsl;
    launch(2'b01, 4'd4, 16'h0001);
    wait_done(1);
  endtask

  task automatic test_right_shifts;
    launch(2'b11, 4'd3, 16'h8000);
    wait_done(1);
    launch(2'b10, 4'd3, 16'h8000);
    wait_done(1);
  endtask

  task automatic test_saturate;
    launch(2'b10, 4'd15, 16'h8000);
    wait_done(1);
    launch(2'b01, 4'd15, 16'hFFFF);
    wait_done(1);
    launch(2'b11, 4'd15, 16'h8001);
    wait_done(1);
  endtask

  task automatic test_zero_work;
    launch(2'b00, 4'd7, 16'hA5A5);
    wait_done(1);
    launch(2'b01, 4'd0, 16'hA5A5);
    wait_done(1);
  endtask

  task automatic test_ignore;
    exp_t e;
    launch(2'b01, 4'd5, 16'h0003);
`ifndef ITER_SHIFT_FAST_EN
    // start pulse while shifting must be dropped
    bus.start  = 1'b1;
    bus.op     = 2'b10;
    bus.amount = 4'd1;
    bus.din    = 16'h1234;
    @(negedge clk);
    cyc++;
    bus.start = 1'b0;
`endif
    wait_done(0);
    // start pulse in the DONE cycle must be dropped too
    bus.start  = 1'b1;
    bus.op     = 2'b10;
    bus.amount = 4'd1;
    bus.din    = 16'h1234;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done_ignored: got busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    // same start held into the first IDLE cycle is accepted
    e.res = model_res(2'b10, 4'd1, 16'h1234);
    e.lat = model_lat(2'b10, 4'd1);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    wait_done(1);
  endtask

  task automatic test_async_reset;
    launch(2'b01, 4'd10, 16'h0001);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dout !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b dout=%h required 0 0 0000", bus.busy, bus.done, bus.dout);
    end
    void'(sb.pop_front());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL no_done_after_abort: got busy=%b done=%b required 0 0", bus.busy, bus.done);
      end
    end
    launch(2'b01, 4'd10, 16'h0001);
    wait_done(1);
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_right_shifts();
    test_saturate();
    test_zero_work();
    test_ignore();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
